// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared states, PS/2 command constants and frame builder for the host transmitter
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_INHIBIT, ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE} state_t;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE = 8'hFA;
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a PS/2 command issuer and the host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic tx_done;
  logic tx_error;
  logic rx_inhibit;
  modport master(output tx_data, tx_start, input tx_busy, tx_done, tx_error, rx_inhibit);
  modport slave(input tx_data, tx_start, output tx_busy, tx_done, tx_error, rx_inhibit);
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, stability filter and falling-edge strobe for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic pclk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  logic [1:0] sync;
  logic [FW-1:0] cnt;
  always_ff @(posedge pclk) begin
    if (rst) begin
      sync <= 2'b11;
      level <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      fall <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == F_LAST) begin
        level <= sync[1];
        fall <= level;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, shift, ACK check).
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out frame up to RETRY_MAX times.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int SETUP_CYCLES = 40,
  parameter int TIMEOUT_CYCLES = 600000,
`ifdef PS2_TX_RETRY_EN
  parameter int RETRY_MAX = 2,
`endif
  parameter int FILTER_LEN = 8
) (
  input  logic pclk,
  input  logic rst,
  ps2_host_tx_if.slave bus,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_oe,
  output logic ps2_data_oe
);
  localparam int CW = $clog2(INHIBIT_CYCLES + SETUP_CYCLES + TIMEOUT_CYCLES);
  localparam logic [CW-1:0] I_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t st;
  logic [CW-1:0] cnt;
  logic [3:0] ecnt;
  logic [9:0] sr;
  logic nack, busy, done, err;
  logic clk_lvl, clk_fall, data_lvl, data_fall, watch, fail;
`ifdef PS2_TX_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1) + 1;
  localparam logic [RW-1:0] R_LAST = RW'(RETRY_MAX);
  logic [RW-1:0] rcnt;
  logic [7:0] byte_q;
`endif
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (.pclk(pclk), .rst(rst), .pin(ps2_clk_in), .level(clk_lvl), .fall(clk_fall));
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data (.pclk(pclk), .rst(rst), .pin(ps2_data_in), .level(data_lvl), .fall(data_fall));
  assign watch = st inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE};
  assign fail = (watch && cnt == T_LAST) || (st == ST_WAIT_IDLE && clk_lvl && data_lvl && nack);
  assign bus.tx_busy = busy;
  assign bus.rx_inhibit = busy;
  assign bus.tx_done = done;
  assign bus.tx_error = err;
  always_ff @(posedge pclk) begin
    if (rst) begin
      st <= ST_IDLE;
      cnt <= '0;
      ecnt <= '0;
      sr <= '0;
      nack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      rcnt <= '0;
      byte_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      // any device activity on either line refreshes the timeout
      cnt <= (watch && (clk_fall || data_fall)) ? '0 : cnt + 1'b1;
      if (fail) begin
        cnt <= '0;
        ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
        if (rcnt != R_LAST) begin
          st <= ST_INHIBIT;
          ps2_clk_oe <= 1'b1;
          ecnt <= '0;
          sr <= ps2_frame(byte_q);
          rcnt <= rcnt + 1'b1;
        end else
`endif
        begin
          st <= ST_IDLE;
          ps2_clk_oe <= 1'b0;
          busy <= 1'b0;
          err <= 1'b1;
        end
      end else begin
        case (st)
          ST_IDLE: if (bus.tx_start) begin
            st <= ST_INHIBIT;
            busy <= 1'b1;
            ps2_clk_oe <= 1'b1;
            cnt <= '0;
            ecnt <= '0;
            sr <= ps2_frame(bus.tx_data);
`ifdef PS2_TX_RETRY_EN
            rcnt <= '0;
            byte_q <= bus.tx_data;
`endif
          end
          ST_INHIBIT: if (cnt == I_LAST) begin
            st <= ST_REQ;
            ps2_data_oe <= 1'b1;
            cnt <= '0;
          end
          ST_REQ: if (cnt == S_LAST) begin
            st <= ST_SHIFT;
            ps2_clk_oe <= 1'b0;
            cnt <= '0;
          end
          ST_SHIFT: if (clk_fall) begin
            ps2_data_oe <= ~sr[0];
            sr <= sr >> 1;
            ecnt <= ecnt + 1'b1;
            if (ecnt == 4'd9) begin
              st <= ST_ACK;
              cnt <= '0;
            end
          end
          ST_ACK: if (clk_fall) begin
            nack <= data_lvl;
            st <= ST_WAIT_IDLE;
            cnt <= '0;
          end
          ST_WAIT_IDLE: if (clk_lvl && data_lvl) begin
            st <= ST_IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench with an open-drain PS/2 device model and frame reference model
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;
  localparam int INH = 4000;
  localparam int SET = 40;
  localparam int TO = 3000;
`ifdef PS2_TX_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err = 0;
  ps2_host_tx_if bus();
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;
  ps2_host_tx #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst(rst), .bus(bus), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));
  always #5 pclk = ~pclk;
  always @(negedge pclk) begin
    if (bus.tx_done) n_done++;
    if (bus.tx_error) n_err++;
  end
  // line bits as the device sees them: start, d0..d7, odd parity, stop
  function automatic logic [10:0] exp_bits(input logic [7:0] d);
    logic [10:0] e;
    e[0] = 1'b0;
    for (int k = 0; k < 8; k++) e[k+1] = d[k];
    e[9] = ($countones(d) % 2 == 0);
    e[10] = 1'b1;
    return e;
  endfunction
  task automatic send(input logic [7:0] d);
    @(negedge pclk);
    bus.tx_data = d;
    bus.tx_start = 1'b1;
    @(negedge pclk);
    bus.tx_start = 1'b0;
  endtask
  task automatic wait_end(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge pclk);
      ok = bus.tx_done | bus.tx_error;
    end
  endtask
  // device clocks out one frame; bits are the host data level seen before each falling edge
  task automatic device_frame(input logic ack, input int cut, input logic glitch, output logic [10:0] bits);
    int w;
    bits = 'x;
    w = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 10000) begin
      @(negedge pclk);
      w++;
    end
    if (w >= 10000) return;
    repeat (30) @(negedge pclk);
    for (int i = 0; i < 11; i++) begin
      bits[i] = ~ps2_data_oe;
      dev_clk = 1'b0;
      if (i == cut) begin
        repeat (15) @(negedge pclk);
        return;
      end
      repeat (20) @(negedge pclk);
      dev_clk = 1'b1;
      if (i == 9) dev_data = ~ack;
      if (i == 10) begin
        dev_data = 1'b1;
        return;
      end
      if (glitch) begin
        repeat (5) @(negedge pclk);
        dev_clk = 1'b0;
        repeat (3) @(negedge pclk);
        dev_clk = 1'b1;
        repeat (12) @(negedge pclk);
      end else repeat (20) @(negedge pclk);
    end
  endtask
  task automatic test_reset();
    logic [5:0] o;
    bus.tx_start = 1'b0;
    bus.tx_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    o = {bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_inhibit, ps2_clk_oe, ps2_data_oe};
    checks++;
    if (o !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b want 000000", o); end
    rst = 1'b0;
    repeat (20) @(negedge pclk);
    o = {bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_inhibit, ps2_clk_oe, ps2_data_oe};
    checks++;
    if (o !== 6'b0) begin errors++; $display("FAIL idle_outputs: got %b want 000000", o); end
  endtask
  task automatic test_ack_f4();
    int hi, first, nd, ne;
    logic [10:0] b;
    logic ok;
    nd = n_done;
    ne = n_err;
    hi = 0;
    first = 0;
    send(PS2_CMD_ENABLE);
    checks++;
    if ({bus.tx_busy, bus.rx_inhibit} !== 2'b11) begin errors++; $display("FAIL busy_on_accept: got %b want 11", {bus.tx_busy, bus.rx_inhibit}); end
    for (int c = 1; c <= 6000; c++) begin
      if (ps2_clk_oe) hi++;
      if (ps2_data_oe && first == 0) first = c;
      if (!ps2_clk_oe) break;
      @(negedge pclk);
    end
    checks++;
    if (hi != INH + SET) begin errors++; $display("FAIL clk_inhibit_len: got %0d want %0d", hi, INH + SET); end
    checks++;
    if (first - 1 != INH) begin errors++; $display("FAIL data_rts_delay: got %0d want %0d", first - 1, INH); end
    device_frame(1'b1, 11, 1'b0, b);
    checks++;
    if (b !== 11'b10111101000) begin errors++; $display("FAIL f4_pattern: got %b want 10111101000", b); end
    wait_end(ok);
    @(negedge pclk);
    checks++;
    if (!ok || n_done - nd != 1 || n_err - ne != 0 || bus.tx_busy !== 1'b0)
      begin errors++; $display("FAIL f4_result: ended %b done %0d err %0d busy %b want 1 1 0 0", ok, n_done - nd, n_err - ne, bus.tx_busy); end
  endtask
  task automatic test_random();
    logic [7:0] d;
    logic ack, ok;
    logic [10:0] b;
    int nd, ne;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      ack = (n == 0) ? 1'b1 : 1'($urandom);
      nd = n_done;
      ne = n_err;
      send(d);
      for (int a = 0; a < (ack ? 1 : ATT); a++) begin
        device_frame(ack, 11, 1'b0, b);
        checks++;
        if (b !== exp_bits(d)) begin errors++; $display("FAIL rand_bits %02h try %0d: got %b want %b", d, a, b, exp_bits(d)); end
      end
      wait_end(ok);
      @(negedge pclk);
      checks++;
      if (!ok || n_done - nd != int'(ack) || n_err - ne != int'(!ack) || bus.tx_busy !== 1'b0)
        begin errors++; $display("FAIL rand_result %02h ack %b: done %0d err %0d busy %b", d, ack, n_done - nd, n_err - ne, bus.tx_busy); end
    end
  endtask
  task automatic test_back_to_back();
    logic [10:0] b;
    logic ok;
    int nd;
    nd = n_done;
    send(8'hA5);
    device_frame(1'b1, 11, 1'b0, b);
    checks++;
    if (b !== exp_bits(8'hA5)) begin errors++; $display("FAIL b2b_bits1: got %b want %b", b, exp_bits(8'hA5)); end
    wait_end(ok);
    bus.tx_data = 8'h3C;
    bus.tx_start = 1'b1;
    @(negedge pclk);
    bus.tx_start = 1'b0;
    checks++;
    if (!ok || bus.tx_busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL b2b_accept: ended %b busy %b clk_oe %b want 1 1 1", ok, bus.tx_busy, ps2_clk_oe); end
    device_frame(1'b1, 11, 1'b0, b);
    checks++;
    if (b !== exp_bits(8'h3C)) begin errors++; $display("FAIL b2b_bits2: got %b want %b", b, exp_bits(8'h3C)); end
    wait_end(ok);
    @(negedge pclk);
    checks++;
    if (n_done - nd != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", n_done - nd); end
  endtask
  task automatic test_nack();
    logic [10:0] b;
    logic ok;
    int nd, ne;
    nd = n_done;
    ne = n_err;
    send(PS2_CMD_RESET);
    for (int a = 0; a < ATT; a++) begin
      device_frame(1'b0, 11, 1'b0, b);
      checks++;
      if (b !== exp_bits(PS2_CMD_RESET)) begin errors++; $display("FAIL nack_bits try %0d: got %b want %b", a, b, exp_bits(PS2_CMD_RESET)); end
    end
    wait_end(ok);
    @(negedge pclk);
    checks++;
    if (!ok || n_done - nd != 0 || n_err - ne != 1 || bus.tx_busy !== 1'b0)
      begin errors++; $display("FAIL nack_result: ended %b done %0d err %0d busy %b want 1 0 1 0", ok, n_done - nd, n_err - ne, bus.tx_busy); end
  endtask
  task automatic test_timeout();
    int w, c, ne;
    logic [3:0] o;
    ne = n_err;
    send(8'h5A);
    w = 0;
    while (ps2_clk_oe && w < 6000) begin @(negedge pclk); w++; end
    c = 0;
    while (!bus.tx_error && !ps2_clk_oe && c < TO + 100) begin @(negedge pclk); c++; end
    checks++;
    if (c != TO) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", c, TO); end
`ifdef PS2_TX_RETRY_EN
    w = 0;
    while (!bus.tx_error && w < 3 * (TO + INH + SET + 100)) begin @(negedge pclk); w++; end
`endif
    o = {bus.tx_error, ps2_clk_oe, ps2_data_oe, bus.tx_busy};
    checks++;
    if (o !== 4'b1000) begin errors++; $display("FAIL timeout_state: err/clk_oe/data_oe/busy got %b want 1000", o); end
    @(negedge pclk);
    checks++;
    if (n_err - ne != 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", n_err - ne); end
  endtask
  task automatic test_reset_mid();
    logic [10:0] b, e;
    logic ok;
    int nd, ne;
    e = exp_bits(PS2_CMD_RESET);
    send(PS2_CMD_RESET);
    device_frame(1'b1, 4, 1'b0, b);
    checks++;
    if (b[4:0] !== e[4:0]) begin errors++; $display("FAIL midreset_prefix: got %b want %b", b[4:0], e[4:0]); end
    rst = 1'b1;
    dev_clk = 1'b1;
    @(negedge pclk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_busy} !== 3'b000) begin errors++; $display("FAIL midreset_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, bus.tx_busy}); end
    rst = 1'b0;
    repeat (50) @(negedge pclk);
    nd = n_done;
    ne = n_err;
    send(PS2_CMD_RESET);
    device_frame(1'b1, 11, 1'b0, b);
    checks++;
    if (b !== e) begin errors++; $display("FAIL postreset_bits: got %b want %b", b, e); end
    wait_end(ok);
    @(negedge pclk);
    checks++;
    if (!ok || n_done - nd != 1 || n_err - ne != 0) begin errors++; $display("FAIL postreset_result: done %0d err %0d want 1 0", n_done - nd, n_err - ne); end
  endtask
  task automatic test_glitch_busy();
    logic [10:0] b;
    logic ok;
    int nd, hi;
    nd = n_done;
    send(PS2_CMD_ENABLE);
    repeat (100) @(negedge pclk);
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b1;
    @(negedge pclk);
    bus.tx_start = 1'b0;
    device_frame(1'b1, 11, 1'b1, b);
    checks++;
    if (b !== exp_bits(PS2_CMD_ENABLE)) begin errors++; $display("FAIL glitch_bits: got %b want %b", b, exp_bits(PS2_CMD_ENABLE)); end
    wait_end(ok);
    hi = 0;
    repeat (500) begin
      @(negedge pclk);
      if (ps2_clk_oe) hi++;
    end
    checks++;
    if (!ok || n_done - nd != 1 || hi != 0) begin errors++; $display("FAIL glitch_single_frame: done %0d extra_inhibit %0d want 1 0", n_done - nd, hi); end
  endtask
  initial begin
    test_reset();
    test_ack_f4();
    test_random();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_glitch_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
